gray_frame_expand: RTL

//  Consumer-side inverse of the RGB->grayscale front end.

---
 rtl/gray_frame_expand_pkg.sv | 28 ++
 rtl/gray_frame_expand_xy_counter.sv | 49 ++++
 rtl/gray_frame_expand.sv | 110 +++++++++++
 3 files changed

// File: rtl/gray_frame_expand_pkg.sv
// Shared frame geometry, pixel type and FSM encoding for the gray-to-RGB frame expander.
package globals;

  localparam int WIDTH      = 1280;
  localparam int HEIGHT     = 720;
  localparam int STARTING_X = 320;
  localparam int ENDING_X   = 959;
  localparam int STARTING_Y = 360;
  localparam int ENDING_Y   = 719;

  typedef logic [23:0] rgb_t;

  localparam rgb_t FILL_RGB_DEFAULT = 24'h0;

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  // Inclusive unsigned range test; operands are widened so a zero lower bound
  // does not turn into a constant-true compare on a narrow counter.
  function automatic logic inRange(input logic [31:0] value,
                                   input logic [31:0] lo,
                                   input logic [31:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/gray_frame_expand_xy_counter.sv
// Raster position counter: walks x across a line, then y down the frame, wrapping at the end.
module frame_xy_counter
  #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720,
    localparam int XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
  )
  (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_advance,
    input  logic          i_invalidate,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
  );

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_lastX;
  logic          w_lastY;

  assign w_lastX = (r_x == XW'(WIDTH - 1));
  assign w_lastY = (r_y == YW'(HEIGHT - 1));

  // Step one pixel per advance; an invalidate poisons the position so a corrupted FSM is obvious in sim.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_invalidate) begin
      r_x <= 'x;
      r_y <= 'x;
    end else if (i_advance) begin
      if (w_lastX) begin
        r_x <= '0;
        r_y <= w_lastY ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_lastX && w_lastY;

endmodule

// File: rtl/gray_frame_expand.sv
// Expands an ROI-only stream of gray pixels back into a full RGB raster,
// painting every position outside the ROI with a fixed fill colour.
module gray_frame_expand
  import globals::*;
  #(
    parameter int   WIDTH      = globals::WIDTH,
    parameter int   HEIGHT     = globals::HEIGHT,
    parameter int   STARTING_X = globals::STARTING_X,
    parameter int   ENDING_X   = globals::ENDING_X,
    parameter int   STARTING_Y = globals::STARTING_Y,
    parameter int   ENDING_Y   = globals::ENDING_Y,
    parameter rgb_t FILL_RGB   = FILL_RGB_DEFAULT
  )
  (
    input  logic        clock,
    input  logic        reset,
    output logic        in_rd_en,
    input  logic        in_empty,
    input  logic [7:0]  in_dout,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic [23:0] out_din,
    output logic        frame_done
  );

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  state_t        r_state;
  state_t        w_stateNext;
  rgb_t          r_pix;
  rgb_t          w_pixNext;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_last;
  logic          w_inRoi;
  logic          w_rdEn;
  logic          w_wrEn;
  logic          w_advance;
  logic          w_invalidate;

  frame_xy_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_xyCounter (
    .clock        (clock),
    .reset        (reset),
    .i_advance    (w_advance),
    .i_invalidate (w_invalidate),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_last       (w_last)
  );

  assign w_inRoi = inRange(32'(w_x), STARTING_X, ENDING_X) &&
                   inRange(32'(w_y), STARTING_Y, ENDING_Y);

  // State and latched pixel registers; reset drops any half-built pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_LOAD;
      r_pix   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_pix   <= w_pixNext;
    end
  end

  // Load a pixel (pop in the ROI, fill outside), then write it once the output FIFO has room.
  always_comb begin
    w_stateNext  = r_state;
    w_pixNext    = r_pix;
    w_rdEn       = 1'b0;
    w_wrEn       = 1'b0;
    w_advance    = 1'b0;
    w_invalidate = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_inRoi) begin
          if (!in_empty) begin
            w_rdEn      = 1'b1;
            w_pixNext   = {3{in_dout}};
            w_stateNext = S_WRITE;
          end
        end else begin
          w_pixNext   = FILL_RGB;
          w_stateNext = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!out_full) begin
          w_wrEn      = 1'b1;
          w_advance   = 1'b1;
          w_stateNext = S_LOAD;
        end
      end
      default: begin
        w_stateNext  = S_LOAD;
        w_pixNext    = 'x;
        w_invalidate = 1'b1;
      end
    endcase
  end

  assign in_rd_en   = w_rdEn;
  assign out_wr_en  = w_wrEn;
  assign out_din    = w_wrEn ? r_pix : '0;
  assign frame_done = w_wrEn && w_last;

endmodule
